jtcps15_snd_romarb: RTL and testbench

- Arbitrates the sound subsystem's two byte-wide ROM readers onto one SDRAM read slot:
  - Z80 program/bank ROM (512 kB window).
  - QSound sample ROM (8 MB window).
- Each client has a one-byte tag cache, so repeated reads of the same address return without an SDRAM access.
- Sits between the CPS1.5 sound block's rom_*/qsnd_* ports and the SDRAM bank controller.

---
 rtl/jtcps15_snd_pkg.sv | 18 +
 rtl/jtcps15_romarb_cache.sv | 41 ++++
 rtl/jtcps15_snd_romarb.sv | 128 ++++++++++++
 tb/tb_jtcps15_snd_romarb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps15_snd_pkg.sv
// Shared definitions for the CPS1.5 sound ROM arbiter: address widths,
// client identifiers and the arbiter FSM state encoding.
package jtcps15_snd_pkg;

   localparam int Z80_AW  = 19;
   localparam int QS_AW   = 23;
   localparam int SLOT_AW = 23;

   localparam logic CL_Z80 = 1'b0;
   localparam logic CL_QS  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arbState_t;

endpackage

// File: rtl/jtcps15_romarb_cache.sv
// One-byte tag cache for a single ROM client. The hit is combinational, so ok
// follows the client address within the same cycle.
module jtcps15_romarb_cache #(
   parameter int AW = 19
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          fill_i,
   input  logic          fillValid_i,
   input  logic [AW-1:0] fillAddr_i,
   input  logic [7:0]    fillData_i,
   input  logic          cs_i,
   input  logic [AW-1:0] addr_i,
   output logic          hit_o,
   output logic [7:0]    data_o
);

   logic [AW-1:0] tag_q;
   logic [7:0]    data_q;
   logic          valid_q;

   // A fill always stores tag and data; a flush in the same cycle keeps the entry invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (fill_i) begin
         tag_q   <= fillAddr_i;
         data_q  <= fillData_i;
         valid_q <= fillValid_i & ~flush_i;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end
   end

   assign hit_o  = cs_i & valid_q & (addr_i == tag_q);
   assign data_o = data_q;

endmodule

// File: rtl/jtcps15_snd_romarb.sv
// Round-robin arbiter putting the Z80 and QSound ROM readers onto one SDRAM
// read slot, with a one-byte tag cache in front of each client.
module jtcps15_snd_romarb
   import jtcps15_snd_pkg::*;
#(
   parameter logic [SLOT_AW-1:0] Z80_OFFSET  = 23'h00_0000,
   parameter logic [SLOT_AW-1:0] QSND_OFFSET = 23'h08_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [Z80_AW-1:0]  z80_addr,
   input  logic               z80_cs,
   output logic               z80_ok,
   output logic [7:0]         z80_data,
   input  logic [QS_AW-1:0]   qs_addr,
   input  logic               qs_cs,
   output logic               qs_ok,
   output logic [7:0]         qs_data,
   output logic [SLOT_AW-1:0] slot_addr,
   output logic               slot_cs,
   input  logic               slot_ok,
   input  logic [7:0]         slot_data
);

   arbState_t          state_q;
   logic               grant_q;
   logic               last_q;
   logic               flushPend_q;
   logic [QS_AW-1:0]   reqAddr_q;
   logic [SLOT_AW-1:0] slotAddr_q;
   logic               slotCs_q;

   logic z80Hit, qsHit, z80Miss, qsMiss;
   logic grantZ80_d;
   logic fillEn, fillValid, z80Fill, qsFill;

   assign z80Miss = z80_cs & ~z80Hit;
   assign qsMiss  = qs_cs & ~qsHit;

   // Z80 takes the slot when it is the only miss or when QSound was served last.
   assign grantZ80_d = z80Miss & (~qsMiss | (last_q == CL_QS));

   assign fillEn    = (state_q == WAIT) & slot_ok;
   assign fillValid = ~(flush | flushPend_q);
   assign z80Fill   = fillEn & (grant_q == CL_Z80);
   assign qsFill    = fillEn & (grant_q == CL_QS);

   // flushPend_q remembers a flush seen mid-transfer so the returning byte is not trusted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= CL_Z80;
         last_q      <= CL_QS;
         flushPend_q <= 1'b0;
         reqAddr_q   <= '0;
         slotAddr_q  <= '0;
         slotCs_q    <= 1'b0;
      end else begin
         flushPend_q <= (flushPend_q | flush) & (state_q != IDLE) & ~fillEn;
         case (state_q)
            IDLE: begin
               if (z80Miss | qsMiss) begin
                  grant_q  <= grantZ80_d ? CL_Z80 : CL_QS;
                  slotCs_q <= 1'b1;
                  state_q  <= REQ;
                  if (grantZ80_d) begin
                     reqAddr_q  <= {{(QS_AW-Z80_AW){1'b0}}, z80_addr};
                     slotAddr_q <= Z80_OFFSET + {{(SLOT_AW-Z80_AW){1'b0}}, z80_addr};
                  end else begin
                     reqAddr_q  <= qs_addr;
                     slotAddr_q <= QSND_OFFSET + qs_addr;
                  end
               end
            end
            REQ: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (slot_ok) begin
                  last_q   <= grant_q;
                  slotCs_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               slotCs_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign slot_addr = slotAddr_q;
   assign slot_cs   = slotCs_q;

   jtcps15_romarb_cache #(.AW(Z80_AW)) u_z80Cache (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .fill_i      (z80Fill),
      .fillValid_i (fillValid),
      .fillAddr_i  (reqAddr_q[Z80_AW-1:0]),
      .fillData_i  (slot_data),
      .cs_i        (z80_cs),
      .addr_i      (z80_addr),
      .hit_o       (z80Hit),
      .data_o      (z80_data)
   );

   jtcps15_romarb_cache #(.AW(QS_AW)) u_qsCache (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .fill_i      (qsFill),
      .fillValid_i (fillValid),
      .fillAddr_i  (reqAddr_q),
      .fillData_i  (slot_data),
      .cs_i        (qs_cs),
      .addr_i      (qs_addr),
      .hit_o       (qsHit),
      .data_o      (qs_data)
   );

   assign z80_ok = z80Hit;
   assign qs_ok  = qsHit;

endmodule

// File: tb/tb_jtcps15_snd_romarb.sv
// Directed bench for the sound ROM arbiter with a fixed-latency SDRAM model
// and a monitor that logs every slot request address.
module tb_jtcps15_snd_romarb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [18:0] z80_addr = '0;
   logic        z80_cs = 1'b0;
   logic        z80_ok;
   logic [7:0]  z80_data;
   logic [22:0] qs_addr = '0;
   logic        qs_cs = 1'b0;
   logic        qs_ok;
   logic [7:0]  qs_data;
   logic [22:0] slot_addr;
   logic        slot_cs;
   logic        slot_ok = 1'b0;
   logic [7:0]  slot_data = '0;

   int testsRun = 0;
   int testsFailed = 0;

   // SDRAM model and monitor state
   int          lat = 3;
   int          hiCnt = 0;
   int          runLen = 0;
   int          lastRun = 0;
   int          lowRun = 0;
   int          lastGap = 0;
   logic        prevCs = 1'b0;
   logic [22:0] grants[$];

   jtcps15_snd_romarb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .z80_addr  (z80_addr),
      .z80_cs    (z80_cs),
      .z80_ok    (z80_ok),
      .z80_data  (z80_data),
      .qs_addr   (qs_addr),
      .qs_cs     (qs_cs),
      .qs_ok     (qs_ok),
      .qs_data   (qs_data),
      .slot_addr (slot_addr),
      .slot_cs   (slot_cs),
      .slot_ok   (slot_ok),
      .slot_data (slot_data)
   );

   always #5 clk = ~clk;

   // ROM contents as seen through the SDRAM slot
   function automatic logic [7:0] memByte(input logic [22:0] a);
      return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h87;
   endfunction

   // SDRAM answers during the (lat+1)-th cycle slot_cs is high; the monitor logs
   // request addresses, high-run lengths and the low gap before each request.
   always @(negedge clk) begin
      if (slot_cs) begin
         if (!prevCs) begin
            grants.push_back(slot_addr);
            lastGap = lowRun;
            lowRun  = 0;
         end
         hiCnt  = hiCnt + 1;
         runLen = runLen + 1;
      end else begin
         if (prevCs) begin
            lastRun = runLen;
         end
         hiCnt  = 0;
         runLen = 0;
         lowRun = lowRun + 1;
      end
      prevCs    = slot_cs;
      slot_ok   = slot_cs && (hiCnt == lat + 1);
      slot_data = slot_ok ? memByte(slot_addr) : 8'h00;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic zCs, input logic [18:0] zAddr,
                                input logic qCs, input logic [22:0] qAddr);
      z80_cs   = zCs;
      z80_addr = zAddr;
      qs_cs    = qCs;
      qs_addr  = qAddr;
   endtask

   task automatic waitZ80Ok(input string tag, output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cycles++;
         if (z80_ok) break;
      end
      checkOutput(tag, {31'd0, z80_ok}, 32'd1);
   endtask

   task automatic waitQsOk(input string tag, output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         cycles++;
         if (qs_ok) break;
      end
      checkOutput(tag, {31'd0, qs_ok}, 32'd1);
   endtask

   task automatic waitGrants(input string tag, input int n, inout logic okSeen);
      for (int i = 0; i < 60; i++) begin
         if (grants.size() >= n) break;
         tick();
         okSeen = okSeen | z80_ok;
      end
      checkOutput(tag, grants.size(), n);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int   cyc;
      int   base;
      logic seen;

      // Reset state
      repeat (2) tick();
      checkOutput("rst slot_cs", {31'd0, slot_cs}, 32'd0);
      checkOutput("rst slot_addr", {9'd0, slot_addr}, 32'd0);
      checkOutput("rst z80_ok", {31'd0, z80_ok}, 32'd0);
      checkOutput("rst qs_ok", {31'd0, qs_ok}, 32'd0);
      checkOutput("rst z80_data", {24'd0, z80_data}, 32'd0);
      checkOutput("rst qs_data", {24'd0, qs_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Simultaneous misses straight after reset: Z80 first, then QSound
      base = grants.size();
      applyStimulus(1'b1, 19'h00010, 1'b1, 23'h000200);
      seen = 1'b0;
      waitGrants("tie grants", base + 2, seen);
      checkOutput("tie first z80", {9'd0, grants[base]}, 32'h000010);
      checkOutput("tie second qs", {9'd0, grants[base+1]}, 32'h080200);
      waitQsOk("tie qs_ok", cyc);
      checkOutput("tie z80_data", {24'd0, z80_data}, 32'h97);
      checkOutput("tie qs_data", {24'd0, qs_data}, 32'h8D);

      // Z80 alone misses, so it becomes last served
      base = grants.size();
      applyStimulus(1'b1, 19'h00020, 1'b1, 23'h000200);
      waitZ80Ok("z80 solo ok", cyc);
      checkOutput("z80 solo grant", {9'd0, grants[base]}, 32'h000020);
      checkOutput("z80 solo data", {24'd0, z80_data}, 32'hA7);
      checkOutput("qs still hit", {31'd0, qs_ok}, 32'd1);

      // Both miss again: round robin now favours QSound
      base = grants.size();
      applyStimulus(1'b1, 19'h00021, 1'b1, 23'h000201);
      seen = 1'b0;
      waitGrants("rr grants", base + 2, seen);
      checkOutput("rr first qs", {9'd0, grants[base]}, 32'h080201);
      checkOutput("rr second z80", {9'd0, grants[base+1]}, 32'h000021);
      waitZ80Ok("rr z80_ok", cyc);

      // Single Z80 miss with latency 3, then a cached re-read
      applyStimulus(1'b0, 19'h0, 1'b0, 23'h0);
      tick();
      base = grants.size();
      applyStimulus(1'b1, 19'h00123, 1'b0, 23'h0);
      waitZ80Ok("miss z80_ok", cyc);
      checkOutput("miss latency", cyc, 32'd5);
      checkOutput("miss slot_addr", {9'd0, grants[base]}, 32'h000123);
      checkOutput("miss cs cycles", lastRun, 32'd4);
      checkOutput("miss data", {24'd0, z80_data}, 32'hA5);
      repeat (3) tick();
      checkOutput("hit z80_ok", {31'd0, z80_ok}, 32'd1);
      checkOutput("hit no request", grants.size(), base + 1);
      checkOutput("hit slot_cs", {31'd0, slot_cs}, 32'd0);

      // QSound top address wraps around the 8 MB window
      base = grants.size();
      applyStimulus(1'b0, 19'h00123, 1'b1, 23'h7FFFFF);
      waitQsOk("wrap qs_ok", cyc);
      checkOutput("wrap slot_addr", {9'd0, grants[base]}, 32'h07FFFF);
      checkOutput("wrap qs_data", {24'd0, qs_data}, 32'h80);

      // Address changes during WAIT: stale fill, then back-to-back re-request
      applyStimulus(1'b0, 19'h0, 1'b0, 23'h0);
      tick();
      base = grants.size();
      applyStimulus(1'b1, 19'h00010, 1'b0, 23'h0);
      repeat (2) tick();
      z80_addr = 19'h00011;
      seen = 1'b0;
      waitGrants("chg grants", base + 2, seen);
      checkOutput("chg no early ok", {31'd0, seen}, 32'd0);
      checkOutput("chg first addr", {9'd0, grants[base]}, 32'h000010);
      checkOutput("chg second addr", {9'd0, grants[base+1]}, 32'h000011);
      checkOutput("chg idle gap", lastGap, 32'd1);
      waitZ80Ok("chg z80_ok", cyc);
      checkOutput("chg data", {24'd0, z80_data}, 32'h96);

      // Flush during a QSound WAIT: fill is discarded and both clients re-request
      base = grants.size();
      applyStimulus(1'b1, 19'h00011, 1'b1, 23'h000040);
      checkOutput("fl z80 hit before", {31'd0, z80_ok}, 32'd1);
      repeat (2) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("fl z80 dropped", {31'd0, z80_ok}, 32'd0);
      seen = 1'b0;
      waitGrants("fl grants", base + 2, seen);
      checkOutput("fl qs not valid", {31'd0, qs_ok}, 32'd0);
      checkOutput("fl first qs", {9'd0, grants[base]}, 32'h080040);
      checkOutput("fl z80 refetch", {9'd0, grants[base+1]}, 32'h000011);
      waitGrants("fl qs again", base + 3, seen);
      checkOutput("fl qs refetch", {9'd0, grants[base+2]}, 32'h080040);
      waitQsOk("fl qs_ok", cyc);
      checkOutput("fl qs_data", {24'd0, qs_data}, 32'hCF);
      checkOutput("fl z80_ok", {31'd0, z80_ok}, 32'd1);

      // Asynchronous reset in the middle of a transfer
      applyStimulus(1'b1, 19'h00030, 1'b1, 23'h000040);
      repeat (2) tick();
      checkOutput("ar slot_cs before", {31'd0, slot_cs}, 32'd1);
      checkOutput("ar qs_ok before", {31'd0, qs_ok}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar slot_cs", {31'd0, slot_cs}, 32'd0);
      checkOutput("ar slot_addr", {9'd0, slot_addr}, 32'd0);
      checkOutput("ar qs_ok", {31'd0, qs_ok}, 32'd0);
      checkOutput("ar z80_ok", {31'd0, z80_ok}, 32'd0);
      tick();
      base = grants.size();
      rst_n = 1'b1;
      seen = 1'b0;
      waitGrants("ar grant", base + 1, seen);
      checkOutput("ar z80 first", {9'd0, grants[base]}, 32'h000030);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
